// File: rtl/mode_counter_pkg.sv
// Shared types and constants for the front-panel mode/counter controller.
// Mode encoding is also what appears on the mode output pins.
package mode_counter_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'b00,
      UP    = 2'b01,
      DOWN  = 2'b10,
      HOLD  = 2'b11
   } mode_t;

   // Idle level of the active-low push buttons
   localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Synchroniser, stable-level debouncer and one-cycle press pulse for one
// raw active-low push button.
module button_debounce
   import mode_counter_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic in_clk,
   input  logic global_reset,
   input  logic btn_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   level_q, level_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   press_q, press_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn_n};
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      // Any cycle that agrees with the accepted level restarts the stability count
      if (synced == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = synced;
         cnt_d   = '0;
         press_d = (synced != BTN_RELEASED);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         sync_q  <= {SYNC_STAGES{BTN_RELEASED}};
         level_q <= BTN_RELEASED;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/mode_counter_ctrl.sv
// Button-stepped 4-mode FSM driving a prescaled up/down counter with
// wrap or clamp at the boundaries and a one-cycle limit pulse.
module mode_counter_ctrl
   import mode_counter_pkg::*;
#(
   parameter int TICK_DIV        = 50_000_000,
   parameter int CNT_WIDTH       = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit SATURATE        = 1'b0
) (
   input  logic                 in_clk,
   input  logic                 global_reset,
   input  logic                 btn_up_n,
   input  logic                 btn_down_n,
   output logic [1:0]           mode,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 tick,
   output logic                 limit
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]        PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] ALL_ONES = {CNT_WIDTH{1'b1}};

   logic [1:0] btn_raw;
   logic [1:0] press;
   logic       up_press, dn_press;

   assign btn_raw = {btn_down_n, btn_up_n};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         button_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .in_clk       (in_clk),
            .global_reset (global_reset),
            .btn_n        (btn_raw[gi]),
            .press        (press[gi])
         );
      end
   endgenerate

   assign up_press = press[0];
   assign dn_press = press[1];

   logic [PW-1:0]        pre_q, pre_d;
   mode_t                mode_q, mode_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 limit_q, limit_d;

   assign tick = (pre_q == PRE_LAST);

   always_comb begin
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   always_comb begin
      mode_d = mode_q;
      if (up_press && !dn_press) begin
         case (mode_q)
            CLEAR:   mode_d = UP;
            UP:      mode_d = DOWN;
            default: mode_d = HOLD;
         endcase
      end else if (dn_press && !up_press) begin
         case (mode_q)
            HOLD:    mode_d = DOWN;
            DOWN:    mode_d = UP;
            default: mode_d = CLEAR;
         endcase
      end
   end

   // Counter follows the registered mode, so a same-cycle mode change lands on the next tick
   always_comb begin
      count_d = count_q;
      limit_d = 1'b0;
      if (mode_q == CLEAR) begin
         count_d = '0;
      end else if (tick) begin
         case (mode_q)
            UP: begin
               if (count_q == ALL_ONES) begin
                  limit_d = 1'b1;
                  count_d = SATURATE ? count_q : '0;
               end else begin
                  count_d = count_q + CNT_WIDTH'(1);
               end
            end
            DOWN: begin
               if (count_q == '0) begin
                  limit_d = 1'b1;
                  count_d = SATURATE ? count_q : ALL_ONES;
               end else begin
                  count_d = count_q - CNT_WIDTH'(1);
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         pre_q   <= '0;
         mode_q  <= CLEAR;
         count_q <= '0;
         limit_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         limit_q <= limit_d;
      end
   end

   assign mode  = mode_q;
   assign count = count_q;
   assign limit = limit_q;

endmodule

// File: tb/tb_mode_counter_ctrl.sv
// Directed bench for mode_counter_ctrl: a wrapping and a clamping instance
// share the same buttons; expectations are hand-computed per clock edge.
module tb_mode_counter_ctrl;

   logic       in_clk;
   logic       global_reset;
   logic       btn_up_n;
   logic       btn_down_n;
   logic [1:0] mode,  mode_s;
   logic [3:0] count, count_s;
   logic       tick,  tick_s;
   logic       limit, limit_s;

   int total = 0;
   int bad   = 0;
   int e     = 0;   // rising edges since the latest reset release

   mode_counter_ctrl #(
      .TICK_DIV(3), .CNT_WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .SATURATE(1'b0)
   ) dut (
      .in_clk(in_clk), .global_reset(global_reset),
      .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .mode(mode), .count(count), .tick(tick), .limit(limit)
   );

   mode_counter_ctrl #(
      .TICK_DIV(3), .CNT_WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .SATURATE(1'b1)
   ) dut_sat (
      .in_clk(in_clk), .global_reset(global_reset),
      .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .mode(mode_s), .count(count_s), .tick(tick_s), .limit(limit_s)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
      end else begin
         $display("ok   %s: %0d (edge %0d)", tag, got, e);
      end
   endtask

   // Advance to 1 time unit after absolute edge t
   task automatic goto(input int t);
      repeat (t - e) @(posedge in_clk);
      #1;
      e = t;
   endtask

   initial begin
      global_reset = 1'b1;
      btn_up_n     = 1'b1;
      btn_down_n   = 1'b1;
      repeat (3) @(posedge in_clk);
      #1;
      global_reset = 1'b0;
      e = 0;

      // 1: reset state and prescaler
      chk("rst_mode", mode, 0);
      chk("rst_count", count, 0);
      chk("rst_limit", limit, 0);
      chk("rst_tick", tick, 0);
      goto(2);  chk("tick_c2", tick, 1);
      goto(3);  chk("tick_c3", tick, 0);  chk("clear_count", count, 0);
      goto(5);  chk("tick_c5", tick, 1);  chk("clear_count2", count, 0);

      // 2: up-press, 7-edge latency, counting
      btn_up_n = 1'b0;
      goto(11); chk("up_lat_before", mode, 0);
      goto(12); chk("up_lat_edge", mode, 1);
      goto(15); chk("up_cnt1", count, 1);
      goto(17); chk("up_held", mode, 1);
      btn_up_n = 1'b1;
      goto(18); chk("up_cnt2", count, 2);
      goto(25); chk("release_mode", mode, 1); chk("up_cnt4", count, 4);

      // 3: three-cycle down glitch is ignored
      btn_down_n = 1'b0;
      goto(28); btn_down_n = 1'b1;
      goto(40); chk("glitch_mode", mode, 1); chk("glitch_cnt", count, 9);
      chk("sat_cnt9", count_s, 9);

      // 4: UP boundary, wrap vs clamp
      goto(57); chk("wrap_pre", count, 15); chk("sat_pre", count_s, 15);
      goto(60); chk("wrap_cnt", count, 0);  chk("wrap_limit", limit, 1);
      chk("clamp_cnt", count_s, 15); chk("clamp_limit", limit_s, 1);
      goto(61); chk("wrap_limit_end", limit, 0); chk("clamp_limit_end", limit_s, 0);

      // UP -> DOWN, then DOWN boundary
      btn_up_n = 1'b0;
      goto(67); chk("down_lat_before", mode, 1);
      goto(68); chk("down_lat_edge", mode, 2);
      goto(69); chk("down_first", count, 1); chk("sat_down_first", count_s, 14);
      goto(70); btn_up_n = 1'b1;
      goto(72); chk("down_zero", count, 0);
      goto(75); chk("down_wrap_cnt", count, 15); chk("down_wrap_limit", limit, 1);
      goto(76); chk("down_wrap_limit_end", limit, 0);
      goto(111); chk("sat_down_zero", count_s, 0); chk("sat_down_nolimit", limit_s, 0);
      goto(114); chk("sat_clamp0_cnt", count_s, 0); chk("sat_clamp0_limit", limit_s, 1);
      chk("wrap_down_cnt", count, 2);
      goto(115); chk("sat_clamp0_limit_end", limit_s, 0);

      // 5: simultaneous presses cancel, then up-press alone -> HOLD
      btn_up_n   = 1'b0;
      btn_down_n = 1'b0;
      goto(122); chk("both_edge", mode, 2);
      goto(125); chk("both_mode", mode, 2); chk("both_mode_sat", mode_s, 2);
      goto(127); btn_up_n = 1'b1; btn_down_n = 1'b1;
      goto(140); btn_up_n = 1'b0;
      goto(146); chk("hold_before", mode, 2);
      goto(147); chk("hold_mode", mode, 3); chk("hold_old_mode_tick", count, 7);
      goto(150); btn_up_n = 1'b1;
      goto(156); chk("hold_frozen", count, 7); chk("hold_frozen_sat", count_s, 0);
      chk("hold_mode_sat", mode_s, 3);

      // 6: fresh start, run to count=9 in UP, reset mid-debounce
      global_reset = 1'b1;
      @(posedge in_clk);
      #1;
      global_reset = 1'b0;
      e = 0;
      chk("rst2_mode", mode, 0);
      goto(5);  btn_up_n = 1'b0;
      goto(12); chk("rst2_up", mode, 1);
      goto(17); btn_up_n = 1'b1;
      goto(39); chk("rst2_cnt9", count, 9); chk("rst2_cnt9_sat", count_s, 9);
      goto(40); btn_down_n = 1'b0;
      goto(43);
      #2 global_reset = 1'b1;
      #1;
      chk("async_mode", mode, 0);
      chk("async_count", count, 0);
      chk("async_limit", limit, 0);
      chk("async_tick", tick, 0);
      chk("async_count_sat", count_s, 0);
      btn_down_n = 1'b1;
      @(posedge in_clk);
      #1;
      global_reset = 1'b0;
      e = 0;
      goto(1);  chk("rst3_tick_c1", tick, 0);
      goto(2);  chk("rst3_tick_c2", tick, 1);
      goto(20); chk("rst3_no_press", mode, 0); chk("rst3_count", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
